// File: rtl/uart_pkg.sv
// Shared types and constants for the UART frame sender: transmitter states,
// parity modes and the frame-length rule.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Clock cycles on the line for one complete frame.
    function automatic int frame_len(input int clk_div, input int data_bits,
                                     input int parity, input int stop_bits);
        return clk_div * (1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data and an occupancy count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == FULL_LVL);
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage is left unreset so it can map onto RAM; a push in a reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (do_push && !reset)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_frame_sender.sv
// FIFO-buffered UART transmitter: start bit, LSB-first data, optional parity,
// one or two stop bits; frames are sent back-to-back while words are queued.
module uart_frame_sender
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        Clk,
    input  logic                        reset,
    input  logic [DATA_BITS-1:0]        in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        UART_Out,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_MAX   = CW'(CLK_DIV - 1);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic          ODD_MODE  = (PARITY == PAR_ODD);

    tx_state_e            state;
    logic [CW-1:0]        cnt;
    logic [3:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;

    logic                 push;
    logic                 pop;
    logic                 full;
    logic                 empty;
    logic [DATA_BITS-1:0] head;
    logic                 bit_end;
    logic                 stop_done;

    assign in_ready  = !full;
    assign push      = in_valid && !full;
    assign bit_end   = (cnt == CNT_MAX);
    assign stop_done = (state == ST_STOP) && bit_end && (bit_idx == LAST_STOP);
    // The next word leaves the FIFO either from idle or on the last stop cycle.
    assign pop       = !empty && ((state == ST_IDLE) || stop_done);
    assign busy      = (state != ST_IDLE) || !empty;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (Clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (in_data),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    always_ff @(posedge Clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            UART_Out <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt      <= '0;
                    bit_idx  <= '0;
                    UART_Out <= 1'b1;
                    if (!empty) begin
                        shreg    <= head;
                        par_bit  <= (^head) ^ ODD_MODE;
                        state    <= ST_START;
                        UART_Out <= 1'b0;
                    end
                end
                ST_START: begin
                    cnt <= cnt + 1'b1;
                    if (bit_end) begin
                        cnt      <= '0;
                        bit_idx  <= '0;
                        state    <= ST_DATA;
                        UART_Out <= shreg[0];
                    end
                end
                ST_DATA: begin
                    cnt <= cnt + 1'b1;
                    if (bit_end) begin
                        cnt <= '0;
                        if (bit_idx == LAST_DATA) begin
                            bit_idx <= '0;
                            if (PARITY != PAR_NONE) begin
                                state    <= ST_PARITY;
                                UART_Out <= par_bit;
                            end else begin
                                state    <= ST_STOP;
                                UART_Out <= 1'b1;
                            end
                        end else begin
                            bit_idx  <= bit_idx + 1'b1;
                            shreg    <= shreg >> 1;
                            UART_Out <= shreg[1];
                        end
                    end
                end
                ST_PARITY: begin
                    cnt <= cnt + 1'b1;
                    if (bit_end) begin
                        cnt      <= '0;
                        bit_idx  <= '0;
                        state    <= ST_STOP;
                        UART_Out <= 1'b1;
                    end
                end
                ST_STOP: begin
                    cnt <= cnt + 1'b1;
                    if (bit_end) begin
                        cnt <= '0;
                        if (bit_idx == LAST_STOP) begin
                            bit_idx <= '0;
                            // Chain straight into the next start bit when more data waits.
                            if (!empty) begin
                                shreg    <= head;
                                par_bit  <= (^head) ^ ODD_MODE;
                                state    <= ST_START;
                                UART_Out <= 1'b0;
                            end else begin
                                state    <= ST_IDLE;
                                UART_Out <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    UART_Out <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_sender.sv
// Bench for uart_frame_sender: four configurations (8N1 depth 4, 8E1, 8O1, 7N2)
// with frame tables, corner sequences and a line receiver fed by random traffic.
module tb_uart_frame_sender;
    import uart_pkg::*;

    logic       Clk = 1'b0;
    logic       reset = 1'b1;
    logic       v0 = 1'b0, v1 = 1'b0, v2 = 1'b0, v3 = 1'b0;
    logic [7:0] d0 = '0, d1 = '0, d2 = '0;
    logic [6:0] d3 = '0;
    logic [3:0] line, busyv, rdy;
    logic [2:0] lvl0;
    logic [4:0] lvl1, lvl2, lvl3;

    int   checks = 0;
    int   errors = 0;
    logic rx_en = 1'b0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    typedef struct {
        int          inst;
        logic [7:0]  data;
        logic [12:0] bits;
        int          nbits;
    } vec_t;
    vec_t tbl[8];

    always #5 Clk = ~Clk;

    uart_frame_sender #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
        .Clk(Clk), .reset(reset), .in_data(d0), .in_valid(v0), .in_ready(rdy[0]),
        .UART_Out(line[0]), .busy(busyv[0]), .fifo_level(lvl0));
    uart_frame_sender #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16)) u_8e1 (
        .Clk(Clk), .reset(reset), .in_data(d1), .in_valid(v1), .in_ready(rdy[1]),
        .UART_Out(line[1]), .busy(busyv[1]), .fifo_level(lvl1));
    uart_frame_sender #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)) u_8o1 (
        .Clk(Clk), .reset(reset), .in_data(d2), .in_valid(v2), .in_ready(rdy[2]),
        .UART_Out(line[2]), .busy(busyv[2]), .fifo_level(lvl2));
    uart_frame_sender #(.CLK_DIV(4), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(16)) u_7n2 (
        .Clk(Clk), .reset(reset), .in_data(d3), .in_valid(v3), .in_ready(rdy[3]),
        .UART_Out(line[3]), .busy(busyv[3]), .fifo_level(lvl3));

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input int idx, input logic v, input logic [7:0] d);
        case (idx)
            0: begin v0 = v; d0 = d; end
            1: begin v1 = v; d1 = d; end
            2: begin v2 = v; d2 = d; end
            default: begin v3 = v; d3 = d[6:0]; end
        endcase
    endtask

    // One-cycle push; returns just after the capturing edge.
    task automatic push_one(input int idx, input logic [7:0] d);
        set_in(idx, 1'b1, d);
        @(posedge Clk); #1;
        set_in(idx, 1'b0, 8'h00);
    endtask

    // Every bit must hold its value for all 4 cycles of the bit period.
    task automatic check_frame(input int idx, input logic [12:0] bits, input int nbits);
        for (int b = 0; b < nbits; b++) begin
            logic got;
            got = bits[b];
            for (int c = 0; c < 4; c++) begin
                @(negedge Clk);
                if (line[idx] !== bits[b]) got = line[idx];
                if (b == nbits - 1 && c == 3) chk("busy during last stop cycle", 16'(busyv[idx]), 16'd1);
            end
            chk($sformatf("inst %0d line bit %0d", idx, b), 16'(got), 16'(bits[b]));
        end
    endtask

    task automatic check_idle_after(input int idx);
        @(negedge Clk);
        chk("busy after frame", 16'(busyv[idx]), 16'd0);
        chk("line idle after frame", 16'(line[idx]), 16'd1);
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        @(negedge Clk);
        while (busyv[0] && n < limit) begin
            @(negedge Clk);
            n++;
        end
        chk("idle within budget", 16'(busyv[0]), 16'd0);
    endtask

    task automatic compare_q(input string name);
        int n;
        chk({name, " word count"}, 16'(rx_q.size()), 16'(exp_q.size()));
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk($sformatf("%s word %0d", name, i), 16'(rx_q[i]), 16'(exp_q[i]));
        rx_q.delete();
        exp_q.delete();
    endtask

    // Line-level receiver for the 8N1 instance: finds a start bit, then reads
    // ten 4-cycle bits and queues the decoded byte.
    initial begin
        logic [9:0] fr;
        logic       diff;
        forever begin
            @(negedge Clk);
            if (rx_en && line[0] === 1'b0) begin
                fr = '0;
                for (int b = 0; b < 10; b++) begin
                    if (b != 0) @(negedge Clk);
                    fr[b] = line[0];
                    diff  = fr[b];
                    for (int c = 1; c < 4; c++) begin
                        @(negedge Clk);
                        if (line[0] !== fr[b]) diff = line[0];
                    end
                    chk("rx bit held 4 cycles", 16'(diff), 16'(fr[b]));
                end
                chk("rx start bit", 16'(fr[0]), 16'd0);
                chk("rx stop bit", 16'(fr[9]), 16'd1);
                rx_q.push_back(fr[8:1]);
            end
        end
    end

    initial begin
        int   limit;
        int   accepted;
        logic seen_full;
        logic v;
        logic [7:0] d;
        logic got;

        // Expected bit strings, first bit on the line in bit 0.
        tbl[0] = '{0, 8'hA5, 13'h34A, 10};
        tbl[1] = '{0, 8'h3C, 13'h278, 10};
        tbl[2] = '{1, 8'hA5, 13'h54A, 11};
        tbl[3] = '{2, 8'hA5, 13'h74A, 11};
        tbl[4] = '{1, 8'h01, 13'h602, 11};
        tbl[5] = '{2, 8'h01, 13'h402, 11};
        tbl[6] = '{3, 8'h7F, 13'h3FE, 10};
        tbl[7] = '{3, 8'h00, 13'h300, 10};
        limit = 8 * frame_len(4, 8, PAR_NONE, 1);

        repeat (3) @(posedge Clk);
        #1 reset = 1'b0;
        @(negedge Clk);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("reset line %0d", i), 16'(line[i]), 16'd1);
            chk($sformatf("reset busy %0d", i), 16'(busyv[i]), 16'd0);
            chk($sformatf("reset ready %0d", i), 16'(rdy[i]), 16'd1);
        end
        chk("reset level 0", 16'(lvl0), 16'd0);
        chk("reset level 1", 16'(lvl1), 16'd0);
        chk("reset level 2", 16'(lvl2), 16'd0);
        chk("reset level 3", 16'(lvl3), 16'd0);

        // Single frames: start bit lands two cycles after the push cycle.
        @(posedge Clk); #1;
        for (int i = 0; i < 8; i++) begin
            push_one(tbl[i].inst, tbl[i].data);
            @(posedge Clk);
            check_frame(tbl[i].inst, tbl[i].bits, tbl[i].nbits);
            check_idle_after(tbl[i].inst);
            @(posedge Clk); #1;
        end

        // 7N2 back-to-back: second start bit follows the 8 stop cycles directly.
        set_in(3, 1'b1, 8'h7F);
        @(posedge Clk); #1;
        set_in(3, 1'b1, 8'h00);
        @(posedge Clk); #1;
        set_in(3, 1'b0, 8'h00);
        check_frame(3, 13'h3FE, 10);
        check_frame(3, 13'h300, 10);
        check_idle_after(3);

        // Depth-4 FIFO under a 10-cycle burst: one word goes straight to the
        // transmitter, four fill the FIFO, the rest are refused.
        rx_en = 1'b1;
        @(posedge Clk); #1;
        accepted  = 0;
        seen_full = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            set_in(0, 1'b1, 8'(i));
            @(negedge Clk);
            if (rdy[0]) begin
                exp_q.push_back(8'(i));
                accepted++;
            end else if (!seen_full) begin
                seen_full = 1'b1;
                chk("level when ready falls", 16'(lvl0), 16'd4);
            end
            @(posedge Clk); #1;
        end
        set_in(0, 1'b0, 8'h00);
        chk("burst words accepted", 16'(accepted), 16'd5);
        wait_idle(limit);
        compare_q("burst");

        // Push coinciding with the end-of-frame pop at level 2.
        @(posedge Clk); #1;
        set_in(0, 1'b1, 8'h11);
        @(posedge Clk); #1;
        set_in(0, 1'b1, 8'h22);
        @(posedge Clk); #1;
        set_in(0, 1'b1, 8'h33);
        @(posedge Clk); #1;
        set_in(0, 1'b0, 8'h00);
        repeat (38) @(posedge Clk);
        #1 set_in(0, 1'b1, 8'h44);
        @(negedge Clk);
        chk("level before push+pop", 16'(lvl0), 16'd2);
        chk("ready before push+pop", 16'(rdy[0]), 16'd1);
        @(posedge Clk); #1;
        set_in(0, 1'b0, 8'h00);
        @(negedge Clk);
        chk("level after push+pop", 16'(lvl0), 16'd2);
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        wait_idle(limit);
        compare_q("push+pop order");

        // Random traffic against the receiver and a queue of accepted words.
        @(posedge Clk); #1;
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 3) == 0);
            d = 8'($urandom);
            set_in(0, v, d);
            @(negedge Clk);
            chk("ready is not-full", 16'(rdy[0]), 16'(lvl0 != 3'd4));
            if (v && rdy[0]) exp_q.push_back(d);
            @(posedge Clk); #1;
        end
        set_in(0, 1'b0, 8'h00);
        wait_idle(limit);
        compare_q("random");
        rx_en = 1'b0;

        // Reset during data bit 3 of 0xA5 with a second word queued.
        @(posedge Clk); #1;
        set_in(0, 1'b1, 8'hA5);
        @(posedge Clk); #1;
        set_in(0, 1'b1, 8'h3C);
        @(posedge Clk); #1;
        set_in(0, 1'b0, 8'h00);
        repeat (17) @(posedge Clk);
        #1;
        reset = 1'b1;
        set_in(0, 1'b1, 8'h55);
        @(negedge Clk);
        chk("line in data bit 3", 16'(line[0]), 16'd0);
        @(posedge Clk); #1;
        reset = 1'b0;
        set_in(0, 1'b0, 8'h00);
        @(negedge Clk);
        chk("line after mid-frame reset", 16'(line[0]), 16'd1);
        chk("level after mid-frame reset", 16'(lvl0), 16'd0);
        chk("busy after mid-frame reset", 16'(busyv[0]), 16'd0);
        chk("ready after mid-frame reset", 16'(rdy[0]), 16'd1);
        got = 1'b1;
        repeat (60) begin
            @(negedge Clk);
            if (line[0] !== 1'b1 || busyv[0] !== 1'b0) got = 1'b0;
        end
        chk("queued words discarded", 16'(got), 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_frame_sender.md
UART_FRAME_SENDER -- requirements
Module: uart_frame_sender

Interface
REQ-001 SHALL have parameter CLK_DIV, default 16: clock cycles per UART bit, legal range 2..65535.
REQ-002 SHALL have parameter DATA_BITS, default 8: data bits per frame, legal range 5..9.
REQ-003 SHALL have parameter PARITY, default 0: 0 = none, 1 = even, 2 = odd.
REQ-004 SHALL have parameter STOP_BITS, default 1: number of stop bits, legal values 1 or 2.
REQ-005 SHALL have parameter FIFO_DEPTH, default 16: input FIFO entries, a power of 2, at least 2.
REQ-006 SHALL have port Clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port in_data, input, DATA_BITS bits: word to transmit.
REQ-009 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-010 SHALL have port in_ready, output, 1 bit: FIFO can accept a word.
REQ-011 SHALL have port UART_Out, output, 1 bit: serial line, idle high.
REQ-012 SHALL have port busy, output, 1 bit: a frame is in progress or the FIFO is not empty.
REQ-013 SHALL have port fifo_level, output, clog2(FIFO_DEPTH)+1 bits: current FIFO occupancy.

Function
REQ-014 SHALL push in_data into the FIFO on every cycle where in_valid and in_ready are both high; in_ready SHALL equal not-full, combinationally.
REQ-015 SHALL ignore in_valid while the FIFO is full; no overwrite and no error flag.
REQ-016 SHALL, on a cycle with a simultaneous push and pop, leave fifo_level unchanged and preserve word order.
REQ-017 SHALL run the transmitter FSM through the states IDLE -> START -> DATA -> PARITY -> STOP -> IDLE; the PARITY state SHALL be skipped when PARITY = 0.
REQ-018 SHALL, in IDLE with the FIFO non-empty, pop one word, load the shift register, and enter START on the next cycle.
REQ-019 SHALL hold each bit on UART_Out for exactly CLK_DIV cycles, using a bit-period counter that restarts at each state or bit change.
REQ-020 SHALL drive: START = 0; DATA = in_data LSB first, DATA_BITS bits; PARITY = XOR of the data bits (even mode) or its inverse (odd mode); STOP = 1 for STOP_BITS × CLK_DIV cycles.
REQ-021 SHALL make the frame length in cycles CLK_DIV × (1 + DATA_BITS + (PARITY != 0) + STOP_BITS).
REQ-022 SHALL give latency: a word pushed in cycle N into an empty FIFO with the FSM in IDLE SHALL drive UART_Out low from cycle N+2.
REQ-023 SHALL, when the FIFO is non-empty at the end of STOP, start the next frame immediately, with no idle cycles between frames.
REQ-024 SHALL hold UART_Out at 1 in IDLE.
REQ-025 SHALL deassert busy only when the FSM is in IDLE and the FIFO is empty.

Reset
REQ-026 SHALL, with reset high at a clock edge, set the FSM to IDLE, empty the FIFO (fifo_level = 0, read and write pointers = 0), and clear the bit counter and shift register.
REQ-027 SHALL, after reset, set UART_Out = 1, busy = 0, and in_ready = 1 on the cycle after the edge.
REQ-028 SHALL, on a reset asserted mid-frame, abort the frame, return UART_Out high on the next cycle, and discard all queued words.
REQ-029 SHALL accept no push in a cycle where reset is high.

Structure
REQ-030 SHALL place the FSM state enum, the parity-mode constants (NONE/EVEN/ODD), and a frame-length function in shared package uart_pkg.
REQ-031 SHALL implement the FIFO as sub-module sync_fifo, parametrised on WIDTH and DEPTH, with push/pop/full/empty/level ports and first-word-fall-through read data.
REQ-032 SHALL implement the transmitter FSM, bit counter and shift register inside uart_frame_sender.

Verification (CLK_DIV = 4 unless stated)
REQ-033 SHALL cover: 8N1, push 0xA5 -> UART_Out from N+2 = 0 then 1,0,1,0,0,1,0,1 then 1, each bit 4 cycles, 40 cycles total; busy falls after the stop bit.
REQ-034 SHALL cover: 8E1 with 0xA5 -> parity bit 0; 8O1 with 0xA5 -> parity bit 1; frame length 44 cycles.
REQ-035 SHALL cover: 7N2, push 0x7F and 0x00 back-to-back -> second start bit immediately follows the 8 stop-cycles of the first frame, with no gap.
REQ-036 SHALL cover: FIFO_DEPTH = 4, hold in_valid high for 10 cycles with data 0x01..0x0A -> in_ready falls with fifo_level = 4; only accepted words appear on the line, in order.
REQ-037 SHALL cover: reset asserted during DATA bit 3 -> UART_Out = 1 and fifo_level = 0 on the next cycle, and the FSM is in IDLE.
REQ-038 SHALL cover: simultaneous push and pop at level 2 -> level stays 2 and the output order is preserved.
